twos_comp_serial_unit: RTL
==========================

Name: twos_comp_serial_unit

Overview:
Parametrised multi-cycle two's-complement conversion unit, the next generation of the fixed 4-bit negator. It processes a WIDTH-bit operand CHUNK bits per cycle through a registered ripple carry, LSB chunk first. Modes are pass, negate, absolute value, and sign-magnitude to two's-complement. It flags overflow and sits between operand registers and the signed calculator datapath behind a valid/ready handshake.

Parameters:
WIDTH, 8, operand/result width; must be >= 2 and an integer multiple of CHUNK.
CHUNK, 2, bits processed per cycle; latency is WIDTH/CHUNK cycles.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
in_valid  input  1  operand present.
in_ready  output  1  unit can accept; high only in IDLE.
a  input  WIDTH  operand.
mode  input  2  00 pass, 01 negate, 10 abs, 11 sign-magnitude to two's complement.
out_valid  output  1  result present; high only in DONE.
out_ready  input  1  consumer accepts result.
y  output  WIDTH  result (registered).
ovf  output  1  overflow for the current result (registered).
busy  output  1  high in BUSY.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, y=0, ovf=0, out_valid=0, busy=0, chunk counter=0, carry=0. in_ready=1 during and after reset.
- States:
  - IDLE -> BUSY on in_valid&&in_ready. Latches a and mode, loads the operand into the work register, clears the counter.
  - BUSY -> DONE after WIDTH/CHUNK cycles.
  - DONE -> IDLE on out_valid&&out_ready.
- Operand/control derived at accept, held constant through BUSY:
  - mode 00: op=a, inv=0, cin=0.
  - mode 01: op=a, inv=1, cin=1.
  - mode 10: op=a, inv=a[WIDTH-1], cin=a[WIDTH-1].
  - mode 11: op={1'b0,a[WIDTH-2:0]}, inv=a[WIDTH-1], cin=a[WIDTH-1].
- Per BUSY cycle i (i=0..WIDTH/CHUNK-1):
  - {carry, res_chunk_i} = (inv ? ~op_chunk_i : op_chunk_i) + carry, with carry initialised to cin.
  - Result chunks are shifted into an internal result register.
  - The carry out of the MSB chunk is discarded (modulo 2^WIDTH).
- On the BUSY->DONE edge:
  - y <= assembled result.
  - ovf <= inv & op[WIDTH-1] & result[WIDTH-1]. This is true only for the most-negative value in modes 01/10; mode 11 never overflows.
- Latency: accept at edge k -> out_valid=1 and y/ovf valid after edge k+WIDTH/CHUNK.
- DONE:
  - y, ovf and out_valid are held stable until out_ready=1.
  - in_ready=0; there is no accept in the same cycle as a result handshake. The next accept is possible one cycle after returning to IDLE.
- y/ovf retain the previous result through IDLE and BUSY. out_valid falls on the DONE->IDLE edge.
- in_valid/a/mode changes during BUSY/DONE are ignored.
- Sign-magnitude negative zero (1000..0, mode 11) -> y=0, ovf=0.
- rst asserted mid-BUSY or in DONE: transaction is discarded, all reset values apply, and no out_valid is produced for it.

Optional Feature:
TWOS_SATURATE_EN:
- Defined: when ovf is set, y is loaded with the most-positive value 0111..1 instead of the wrapped result; ovf is still asserted.
- Undefined: y holds the wrapped result 1000..0 and ovf is asserted.
- No timing or handshake difference either way.

Test Plan:
(WIDTH=8, CHUNK=2, latency 4)
- Negate: a=0x05, mode=01 accepted at edge k -> out_valid=1 after edge k+4, y=0xFB, ovf=0, busy high for 4 cycles.
- Abs: a=0xF6, mode=10 -> y=0x0A, ovf=0. Then a=0x0A, mode=10 -> y=0x0A. Then a=0x37, mode=00 -> y=0x37.
- Sign-magnitude: a=0x85, mode=11 -> y=0xFB. a=0x05 -> y=0x05. a=0x80 -> y=0x00, ovf=0.
- Overflow: a=0x80 with mode=01, then with mode=10 -> ovf=1 both times. y=0x80 without TWOS_SATURATE_EN; y=0x7F with it.
- Backpressure: out_ready=0 for 3 cycles in DONE while in_valid=1 with a new a -> y, ovf and out_valid stable, in_ready=0, new operand not taken. Then out_ready=1 -> IDLE next edge, in_ready=1, new operand accepted one cycle later.
- Reset mid-op: rst=0 during 2nd BUSY cycle -> out_valid=0, y=0, ovf=0, in_ready=1 immediately. After release, a=0x01, mode=01 -> y=0xFF after 4 cycles.

Source files
------------

// File: rtl/twos_comp_serial_unit_if.sv
// twos_comp_serial_unit_if: operand/result handshake bundle for the serial two's-complement unit
interface twos_comp_serial_unit_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             ovf;
    logic             busy;
    modport master (
        output in_valid, a, mode, out_ready,
        input  in_ready, out_valid, y, ovf, busy
    );
    modport slave (
        input  in_valid, a, mode, out_ready,
        output in_ready, out_valid, y, ovf, busy
    );
endinterface

// File: rtl/twos_comp_serial_unit.sv
// twos_comp_serial_unit: chunk-serial pass/negate/abs/sign-magnitude converter, LSB chunk first
// Optional macro TWOS_SATURATE_EN: clamp overflowing results to the most-positive value.
module twos_comp_serial_unit #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input logic                    clk,
    input logic                    rst,
    twos_comp_serial_unit_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] op, res, res_nx, y;
    logic [CW-1:0]    cnt;
    logic             inv, carry, op_msb, ovf, ovf_nx, last, inv_a, accept;
    logic [CHUNK-1:0] chunk;
    logic [CHUNK:0]   sum;

    assign accept = state == IDLE && bus.in_valid;
    assign inv_a  = bus.mode[1] ? bus.a[WIDTH-1] : bus.mode[0];
    assign last   = cnt == CW'(N - 1);
    assign chunk  = inv ? ~op[CHUNK-1:0] : op[CHUNK-1:0];
    assign sum    = {1'b0, chunk} + (CHUNK + 1)'(carry);
    assign res_nx = (res >> CHUNK) | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    assign ovf_nx = inv & op_msb & res_nx[WIDTH-1];

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.busy      = state == BUSY;
    assign bus.y         = y;
    assign bus.ovf       = ovf;

    // state register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_d;

    // next state: accept in IDLE, count chunks in BUSY, wait for consumer in DONE
    always_comb begin
        state_d = state;
        state_d = state == IDLE ? (bus.in_valid ? BUSY : IDLE) :
                  state == BUSY ? (last ? DONE : BUSY) :
                  (bus.out_ready ? IDLE : DONE);
    end

    // datapath: latch operand on accept, ripple one chunk per BUSY cycle, publish on the last one
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            op     <= '0;
            res    <= '0;
            y      <= '0;
            cnt    <= '0;
            inv    <= 1'b0;
            carry  <= 1'b0;
            op_msb <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            op     <= bus.mode == 2'b11 ? {1'b0, bus.a[WIDTH-2:0]} : bus.a;
            op_msb <= bus.mode == 2'b11 ? 1'b0 : bus.a[WIDTH-1];
            inv    <= inv_a;
            carry  <= inv_a;
            cnt    <= '0;
        end else if (state == BUSY) begin
            op    <= op >> CHUNK;
            carry <= sum[CHUNK];
            res   <= res_nx;
            cnt   <= cnt + 1'b1;
            if (last) begin
`ifdef TWOS_SATURATE_EN
                y <= ovf_nx ? {1'b0, {(WIDTH - 1){1'b1}}} : res_nx;
`else
                y <= res_nx;
`endif
                ovf <= ovf_nx;
            end
        end
endmodule
